alu_mdu_iter: RTL and testbench

//  Iterative multiply/divide unit for RV64M/RV32M ops. Shift-add multiplier, radix-2 restoring divider.

---
 rtl/alu_mdu_iter.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_alu_mdu_iter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: iterative RV64M/RV32M multiply/divide unit.
// Shift-add multiplier (MUL_BITS per cycle) and radix-2 restoring divider
// share one 2*XLEN accumulator. Divide-by-zero, signed overflow and illegal
// ops bypass the iteration and produce their result one cycle after accept.
module alu_mdu_iter #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned MUL_BITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int unsigned CW    = 7;
   localparam int unsigned SW    = XLEN + MUL_BITS;
   localparam int unsigned WSH   = XLEN - 32;
   localparam int unsigned AW    = 2 * XLEN;
   localparam bit          HAS_W = (XLEN == 64);

   localparam logic [CW-1:0] MUL_LAST  = CW'(XLEN / MUL_BITS - 1);
   localparam logic [CW-1:0] MULW_LAST = CW'(32 / MUL_BITS - 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(XLEN - 1);
   localparam logic [CW-1:0] DIVW_LAST = CW'(31);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Sign-extend a 32-bit value to XLEN.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // State and datapath registers
   state_t          r_state;
   logic [1:0]      r_sel;
   logic            r_is_div;
   logic            r_is_w;
   logic            r_neg_lo;
   logic            r_neg_hi;
   logic [XLEN-1:0] r_opnd;
   logic [AW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_last;
   logic            r_out_valid;
   logic [XLEN-1:0] r_result;
   logic            r_in_ready;
   logic            r_busy;

   // Next-state values
   state_t          w_state_nxt;
   logic [1:0]      w_sel_nxt;
   logic            w_is_div_nxt;
   logic            w_is_w_nxt;
   logic            w_neg_lo_nxt;
   logic            w_neg_hi_nxt;
   logic [XLEN-1:0] w_opnd_nxt;
   logic [AW-1:0]   w_acc_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [CW-1:0]   w_last_nxt;
   logic            w_out_valid_nxt;
   logic [XLEN-1:0] w_result_nxt;
   logic            w_in_ready_nxt;

   // Operand preparation (accept cycle)
   logic            w_is_div;
   logic            w_is_w;
   logic            w_illegal;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_a_ext;
   logic [XLEN-1:0] w_b_ext;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_abs;
   logic [XLEN-1:0] w_b_abs;
   logic [XLEN-1:0] w_min;
   logic            w_dz;
   logic            w_ovf;
   logic            w_bypass;
   logic [XLEN-1:0] w_byp_res;
   logic [XLEN-1:0] w_dvd;

   // Iteration step and final fix-up
   logic [SW-1:0]   w_mul_sum;
   logic [AW-1:0]   w_acc_mul;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_diff;
   logic            w_q_bit;
   logic [AW-1:0]   w_acc_div;
   logic [AW-1:0]   w_acc_step;
   logic [AW-1:0]   w_prod;
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   logic [XLEN-1:0] w_div_res;
   logic [XLEN-1:0] w_final;

   // Decode the incoming op, form magnitudes and detect bypass cases
   always_comb begin
      w_is_div  = op_i[3];
      w_is_w    = op_i[2];
      w_illegal = (~op_i[3] & op_i[2] & (op_i[1:0] != 2'd0)) | (~HAS_W & op_i[2]);

      if (w_is_div) begin
         w_sa = ~op_i[0];
         w_sb = ~op_i[0];
      end else begin
         w_sa = ~op_i[2] & (op_i[1:0] != 2'd3);
         w_sb = ~op_i[2] & ~op_i[1];
      end

      w_a_ext = rs1_i;
      w_b_ext = rs2_i;
      if (w_is_w) begin
         w_a_ext = w_sa ? sext32(rs1_i[31:0]) : XLEN'(rs1_i[31:0]);
         w_b_ext = w_sb ? sext32(rs2_i[31:0]) : XLEN'(rs2_i[31:0]);
      end

      w_a_neg = w_sa & w_a_ext[XLEN-1];
      w_b_neg = w_sb & w_b_ext[XLEN-1];
      w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
      w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;

      // W dividends are pre-shifted so bit 31 is the first bit consumed
      w_dvd = w_is_w ? (w_a_abs << WSH) : w_a_abs;

      w_min = w_is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      w_dz  = w_is_div & (w_b_ext == '0);
      w_ovf = w_is_div & ~op_i[0] & (w_a_ext == w_min) & (w_b_ext == '1);
      w_bypass = w_illegal | w_dz | w_ovf;

      w_byp_res = '0;
      if (w_illegal) begin
         w_byp_res = '0;
      end else if (w_dz) begin
         w_byp_res = op_i[1] ? (w_is_w ? sext32(rs1_i[31:0]) : rs1_i) : '1;
      end else if (w_ovf) begin
         w_byp_res = op_i[1] ? '0 : w_min;
      end
   end

   // One multiply step (MUL_BITS multiplier bits) and one restoring divide step
   always_comb begin
      w_mul_sum = SW'(r_acc[AW-1:XLEN]) + SW'(r_acc[MUL_BITS-1:0]) * SW'(r_opnd);
      w_acc_mul = {w_mul_sum, r_acc[XLEN-1:MUL_BITS]};

      w_rem_sh  = {r_acc[AW-1:XLEN], r_acc[XLEN-1]};
      w_diff    = w_rem_sh - {1'b0, r_opnd};
      w_q_bit   = ~w_diff[XLEN];
      w_acc_div = {(w_q_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_q_bit};

      w_acc_step = r_is_div ? w_acc_div : w_acc_mul;
   end

   // Sign fix-up and result selection from the final accumulator value
   always_comb begin
      w_prod    = r_neg_lo ? -w_acc_step : w_acc_step;
      w_quo     = r_neg_lo ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
      w_rem     = r_neg_hi ? -w_acc_step[AW-1:XLEN] : w_acc_step[AW-1:XLEN];
      w_div_res = r_sel[1] ? w_rem : w_quo;

      if (r_is_div) begin
         w_final = r_is_w ? sext32(w_div_res[31:0]) : w_div_res;
      end else if (r_is_w) begin
         w_final = sext32(w_acc_step[XLEN-1 -: 32]);
      end else if (r_sel == 2'd0) begin
         w_final = w_prod[XLEN-1:0];
      end else begin
         w_final = w_prod[AW-1:XLEN];
      end
   end

   // FSM next-state and register next values; flush overrides everything
   always_comb begin
      w_state_nxt     = r_state;
      w_sel_nxt       = r_sel;
      w_is_div_nxt    = r_is_div;
      w_is_w_nxt      = r_is_w;
      w_neg_lo_nxt    = r_neg_lo;
      w_neg_hi_nxt    = r_neg_hi;
      w_opnd_nxt      = r_opnd;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_last_nxt      = r_last;
      w_out_valid_nxt = r_out_valid;
      w_result_nxt    = r_result;

      case (r_state)
         ST_IDLE: begin
            if (in_valid_i && !flush_i) begin
               w_sel_nxt    = op_i[1:0];
               w_is_div_nxt = w_is_div;
               w_is_w_nxt   = w_is_w;
               w_neg_lo_nxt = w_a_neg ^ w_b_neg;
               w_neg_hi_nxt = w_a_neg;
               w_opnd_nxt   = w_is_div ? w_b_abs : w_a_abs;
               w_acc_nxt    = w_is_div ? {{XLEN{1'b0}}, w_dvd} : {{XLEN{1'b0}}, w_b_abs};
               w_cnt_nxt    = '0;
               if (w_is_div) begin
                  w_last_nxt = w_is_w ? DIVW_LAST : DIV_LAST;
               end else begin
                  w_last_nxt = w_is_w ? MULW_LAST : MUL_LAST;
               end
               if (w_bypass) begin
                  w_state_nxt     = ST_DONE;
                  w_out_valid_nxt = 1'b1;
                  w_result_nxt    = w_byp_res;
               end else begin
                  w_state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            w_acc_nxt = w_acc_step;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == r_last) begin
               w_state_nxt     = ST_DONE;
               w_out_valid_nxt = 1'b1;
               w_result_nxt    = w_final;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
         end
      endcase

      if (flush_i) begin
         w_state_nxt     = ST_IDLE;
         w_out_valid_nxt = 1'b0;
      end

      w_in_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sel       <= '0;
         r_is_div    <= 1'b0;
         r_is_w      <= 1'b0;
         r_neg_lo    <= 1'b0;
         r_neg_hi    <= 1'b0;
         r_opnd      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_last      <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_is_div    <= w_is_div_nxt;
         r_is_w      <= w_is_w_nxt;
         r_neg_lo    <= w_neg_lo_nxt;
         r_neg_hi    <= w_neg_hi_nxt;
         r_opnd      <= w_opnd_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_result    <= w_result_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_busy      <= ~w_in_ready_nxt;
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign result_o    = r_result;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Testbench for alu_mdu_iter (XLEN=64, MUL_BITS=4): directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// sequences for back-pressure, flush and mid-operation reset.
module tb_alu_mdu_iter;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  op_i;
   logic [63:0] rs1_i;
   logic [63:0] rs2_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] result_o;
   logic        busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   always #5 clk = ~clk;

   alu_mdu_iter #(.XLEN(64), .MUL_BITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // RISC-V M-extension semantics computed with plain wide arithmetic
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [127:0]       pa, pb, p;
      logic signed [63:0] sa, sb;
      logic signed [31:0] wa, wb;
      logic [31:0]        ua, ub;
      logic [31:0]        t32;
      sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      case (op)
         4'd0: return a * b;
         4'd1: begin
            pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64];
         end
         4'd2: begin
            pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64];
         end
         4'd3: begin
            pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64];
         end
         4'd4: begin t32 = ua * ub; return sx32(t32); end
         4'd8: begin
            if (b == 0) return '1;
            if (a == MIN64 && b == '1) return MIN64;
            return sa / sb;
         end
         4'd9:  return (b == 0) ? '1 : a / b;
         4'd10: begin
            if (b == 0) return a;
            if (a == MIN64 && b == '1) return 64'd0;
            return sa % sb;
         end
         4'd11: return (b == 0) ? a : a % b;
         4'd12: begin
            if (ub == 0) return '1;
            if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(32'h8000_0000);
            t32 = wa / wb; return sx32(t32);
         end
         4'd13: begin
            if (ub == 0) return '1;
            t32 = ua / ub; return sx32(t32);
         end
         4'd14: begin
            if (ub == 0) return sx32(ua);
            if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
            t32 = wa % wb; return sx32(t32);
         end
         4'd15: begin
            if (ub == 0) return sx32(ua);
            t32 = ua % ub; return sx32(t32);
         end
         default: return 64'd0;
      endcase
   endfunction

   // Expected accept-to-valid latency from the op class
   function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      bit w, sg, bz, ovf;
      if (op >= 4'd5 && op <= 4'd7) return 1;
      if (op <= 4'd3) return 17;
      if (op == 4'd4) return 9;
      w   = op[2];
      sg  = !op[0];
      bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == MIN64 && b == '1));
      if (bz || ovf) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] pick_val();
      case ($urandom_range(0, 9))
         0: return 64'd0;
         1: return '1;
         2: return MIN64;
         3: return 64'($urandom_range(0, 20));
         4: return 64'h0000_0000_8000_0000;
         5: return 64'h0000_0000_FFFF_FFFF;
         6: return {32'($urandom), 32'h8000_0000};
         7: return -64'($urandom_range(1, 20));
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Present one request at a negedge; returns #1 after the accept edge
   task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      int guard = 0;
      @(negedge clk);
      while (!in_ready_o && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready_o) chk("accept_timeout", {63'd0, in_ready_o}, 64'd1);
      in_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      op_i  = 4'($urandom);
      rs1_i = {32'($urandom), 32'($urandom)};
      rs2_i = {32'($urandom), 32'($urandom)};
   endtask

   // Latency counts the accept edge as 1
   task automatic wait_result(output logic [63:0] res, output int lat);
      lat = 1;
      while (!out_valid_o && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid_o) chk("result_timeout", {63'd0, out_valid_o}, 64'd1);
      res = result_o;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e_res, input int e_lat);
      logic [63:0] res;
      int          lat;
      start_op(op, a, b);
      wait_result(res, lat);
      chk({tag, "_result"}, res, e_res);
      chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
      @(posedge clk); #1;
      chk({tag, "_handoff"}, {63'd0, out_valid_o}, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] res;
      int          lat;
      logic [3:0]  rop;
      logic [63:0] ra, rb;

      vecs[0]  = '{4'd0,  64'd3,                  -64'd5,  64'hFFFF_FFFF_FFFF_FFF1, 17};
      vecs[1]  = '{4'd3,  '1,                     '1,      64'hFFFF_FFFF_FFFF_FFFE, 17};
      vecs[2]  = '{4'd2,  '1,                     64'd2,   64'hFFFF_FFFF_FFFF_FFFF, 17};
      vecs[3]  = '{4'd8,  -64'd7,                 64'd2,   64'hFFFF_FFFF_FFFF_FFFD, 65};
      vecs[4]  = '{4'd10, -64'd7,                 64'd2,   64'hFFFF_FFFF_FFFF_FFFF, 65};
      vecs[5]  = '{4'd13, 64'h1_8000_0000,        64'd1,   64'hFFFF_FFFF_8000_0000, 33};
      vecs[6]  = '{4'd8,  64'd123,                64'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[7]  = '{4'd10, 64'd5,                  64'd0,   64'd5,                   1};
      vecs[8]  = '{4'd8,  MIN64,                  '1,      MIN64,                   1};
      vecs[9]  = '{4'd14, 64'h8000_0000,          '1,      64'd0,                   1};
      vecs[10] = '{4'd4,  64'h7FFF_FFFF,          64'd2,   64'hFFFF_FFFF_FFFF_FFFE, 9};
      vecs[11] = '{4'd5,  64'd9,                  64'd9,   64'd0,                   1};
      vecs[12] = '{4'd1,  '1,                     '1,      64'd0,                   17};
      vecs[13] = '{4'd15, 64'hFFFF_FFFF_8000_0007, 64'hABCD_0000_0000, 64'hFFFF_FFFF_8000_0007, 1};
      vecs[14] = '{4'd9,  64'd100,                64'd7,   64'd14,                  65};
      vecs[15] = '{4'd11, 64'd100,                64'd7,   64'd2,                   65};
      vecs[16] = '{4'd12, 64'h0000_0000_FFFF_FFF8, 64'd3,  64'hFFFF_FFFF_FFFF_FFFE, 33};

      rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      op_i = 4'd0; rs1_i = 64'd0; rs2_i = 64'd0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready",  {63'd0, in_ready_o},  64'd1);
      chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
      chk("reset_busy",      {63'd0, busy_o},      64'd0);
      chk("reset_result",    result_o,             64'd0);

      for (int i = 0; i < 17; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = pick_val();
         rb  = pick_val();
         run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb),
                exp_lat(rop, ra, rb));
      end

      // Back-pressure: result and valid held while the consumer stalls
      out_ready_i = 1'b0;
      start_op(4'd0, 64'd3, -64'd5);
      wait_result(res, lat);
      chk("hold_latency", 64'(lat), 64'd17);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_valid", k),    {63'd0, out_valid_o}, 64'd1);
         chk($sformatf("hold%0d_result", k),   result_o, 64'hFFFF_FFFF_FFFF_FFF1);
         chk($sformatf("hold%0d_in_ready", k), {63'd0, in_ready_o},  64'd0);
      end
      @(negedge clk); out_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("release_valid",    {63'd0, out_valid_o}, 64'd0);
      chk("release_in_ready", {63'd0, in_ready_o},  64'd1);
      chk("release_busy",     {63'd0, busy_o},      64'd0);

      // Flush in CALC cycle 20 with a request present
      start_op(4'd8, 64'd1000, 64'd3);
      repeat (19) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1; in_valid_i = 1'b1; op_i = 4'd0; rs1_i = 64'd7; rs2_i = 64'd7;
      @(posedge clk); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      chk("flush_calc_valid",    {63'd0, out_valid_o}, 64'd0);
      chk("flush_calc_busy",     {63'd0, busy_o},      64'd0);
      chk("flush_calc_in_ready", {63'd0, in_ready_o},  64'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("flush_idle%0d_valid", k), {63'd0, out_valid_o}, 64'd0);
         chk($sformatf("flush_idle%0d_busy", k),  {63'd0, busy_o},      64'd0);
      end

      // Flush in IDLE beats a simultaneous request
      @(negedge clk);
      flush_i = 1'b1; in_valid_i = 1'b1; op_i = 4'd0; rs1_i = 64'd2; rs2_i = 64'd2;
      @(posedge clk); #1;
      flush_i = 1'b0; in_valid_i = 1'b0;
      chk("flush_idle_drop_busy", {63'd0, busy_o}, 64'd0);
      run_op("post_flush_mul", 4'd0, 64'h1234, 64'h10, 64'h12340, 17);

      // Flush while a result is waiting in DONE
      out_ready_i = 1'b0;
      start_op(4'd8, 64'd5, 64'd0);
      wait_result(res, lat);
      chk("flush_done_pre_result", res, '1);
      @(negedge clk); flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("flush_done_valid", {63'd0, out_valid_o}, 64'd0);
      chk("flush_done_busy",  {63'd0, busy_o},      64'd0);
      out_ready_i = 1'b1;

      // Reset in CALC cycle 20 with a request present
      start_op(4'd8, 64'd1000, 64'd3);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; in_valid_i = 1'b1; op_i = 4'd0; rs1_i = 64'd7; rs2_i = 64'd7;
      @(posedge clk); #1;
      rst = 1'b0; in_valid_i = 1'b0;
      chk("rst_calc_valid",    {63'd0, out_valid_o}, 64'd0);
      chk("rst_calc_result",   result_o,             64'd0);
      chk("rst_calc_busy",     {63'd0, busy_o},      64'd0);
      chk("rst_calc_in_ready", {63'd0, in_ready_o},  64'd1);
      repeat (3) @(posedge clk); #1;
      chk("rst_idle_busy",  {63'd0, busy_o},      64'd0);
      chk("rst_idle_valid", {63'd0, out_valid_o}, 64'd0);
      run_op("post_rst_mul", 4'd0, -64'd7, 64'd9, ref_model(4'd0, -64'd7, 64'd9), 17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
